// File: rtl/argmax_stream_if.sv
// ---------------------------------------------------------------------------
// argmax_stream_if
// Bundles the frame control, score stream and result/status signals of the
// streaming argmax unit so they travel as a single port.
//
// Signals:
//   start        : single-cycle pulse opening a new frame
//   in_valid     : score present on in_data
//   in_data      : score, DATA_WIDTH bits
//   in_last      : final score of the frame (qualified by in_valid)
//   in_ready     : unit accepts a score this cycle
//   busy         : frame in progress
//   done         : one-cycle pulse, result just committed
//   result_valid : argmax_index/max_score hold a committed result
//   argmax_index : winning class index, IDX_WIDTH bits
//   max_score    : winning score, DATA_WIDTH bits
//   len_error    : last frame's length did not equal the class count
//
// Modports:
//   master : the score producer / result consumer
//   slave  : the argmax unit
// ---------------------------------------------------------------------------
interface argmax_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic                  result_valid;
    logic [IDX_WIDTH-1:0]  argmax_index;
    logic [DATA_WIDTH-1:0] max_score;
    logic                  len_error;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, busy, done, result_valid, argmax_index, max_score, len_error
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, busy, done, result_valid, argmax_index, max_score, len_error
    );
endinterface

// File: rtl/argmax_stream.sv
// ---------------------------------------------------------------------------
// argmax_stream
// Streaming argmax over one frame of NUM_CLASSES scores. Scores arrive over a
// valid/ready handshake; the unit tracks the running maximum (strictly
// greater wins, so ties keep the lowest index) and publishes the winning
// index and score together with a one-cycle done pulse.
//
// Parameters:
//   DATA_WIDTH  : score width in bits
//   NUM_CLASSES : scores per frame (>= 2)
//   SIGNED      : 1 = two's-complement compare, 0 = unsigned compare
//   IDX_WIDTH   : index/counter width, derived from NUM_CLASSES
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : argmax_stream_if slave modport (stream in, result out)
// ---------------------------------------------------------------------------
module argmax_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10,
    parameter bit SIGNED      = 1'b1,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic           clk,
    input  logic           reset,
    argmax_stream_if.slave bus
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMMIT
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [IDX_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_runMax;
    logic [IDX_WIDTH-1:0]  r_runIdx;
    logic [IDX_WIDTH-1:0]  r_argmaxIndex;
    logic [DATA_WIDTH-1:0] r_maxScore;
    logic                  r_resultValid;
    logic                  r_lenError;

    logic                  w_inReady;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_take;
    logic                  w_atEnd;
    logic                  w_frameEnd;
    logic                  w_greater;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_maxNext;
    logic [IDX_WIDTH-1:0]  w_idxNext;

    // A start in ACCUM aborts the frame, so a coincident handshake is
    // dropped rather than counted towards the new frame.
    assign w_take     = bus.in_valid && (r_state == ACCUM) && !bus.start;
    assign w_atEnd    = (r_count == LAST_IDX);
    assign w_frameEnd = bus.in_last || w_atEnd;

    // Running-max candidate for the sample being taken this cycle. The first
    // sample of a frame always loads, independent of the stale run_max.
    always_comb begin
        w_greater = 1'b0;
        if (SIGNED) begin
            w_greater = $signed(bus.in_data) > $signed(r_runMax);
        end else begin
            w_greater = bus.in_data > r_runMax;
        end
        w_load    = (r_count == '0) || w_greater;
        w_maxNext = w_load ? bus.in_data : r_runMax;
        w_idxNext = w_load ? r_count : r_runIdx;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode. in_ready depends on state only, so there
    // is no combinational path from in_valid back to in_ready.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = ACCUM;
                end
            end
            ACCUM: begin
                w_inReady = 1'b1;
                w_busy    = 1'b1;
                if (w_take && w_frameEnd) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. The result registers load on the terminating handshake edge,
    // which is the same edge that raises done, so the result and the pulse
    // appear together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_runMax      <= '0;
            r_runIdx      <= '0;
            r_argmaxIndex <= '0;
            r_maxScore    <= '0;
            r_resultValid <= 1'b0;
            r_lenError    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_count       <= '0;
                        r_runMax      <= '0;
                        r_runIdx      <= '0;
                        r_resultValid <= 1'b0;
                        r_lenError    <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.start) begin
                        r_count  <= '0;
                        r_runMax <= '0;
                        r_runIdx <= '0;
                    end else if (w_take) begin
                        r_runMax <= w_maxNext;
                        r_runIdx <= w_idxNext;
                        if (w_frameEnd) begin
                            r_count       <= '0;
                            r_argmaxIndex <= w_idxNext;
                            r_maxScore    <= w_maxNext;
                            r_resultValid <= 1'b1;
                            r_lenError    <= bus.in_last ^ w_atEnd;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready     = w_inReady;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.result_valid = r_resultValid;
    assign bus.argmax_index = r_argmaxIndex;
    assign bus.max_score    = r_maxScore;
    assign bus.len_error    = r_lenError;

endmodule
